// File: rtl/hog_feature_stream_packer.sv
// hog_feature_stream_packer
// Reads all HOG result banks in lockstep, converts every fraction to float32
// (or raw / all-ones test pattern), rotates bank order per bin group and packs
// RPB reads into one AXI_DW beat behind a 2-deep ready/valid beat buffer.
module hog_feature_stream_packer #(
  parameter int QN     = 8,
  parameter int NBANK  = 4,
  parameter int AXI_DW = 512,
  parameter int AW     = 13,
  parameter int NBIN   = 31,
  parameter int WPB    = 256,
  parameter int SPLIT1 = 17,
  parameter int SPLIT2 = 26,
  parameter int ROT_A  = 0,
  parameter int ROT_B  = 1,
  parameter int ROT_C  = 3
) (
  input  logic                  aclk,
  input  logic                  arest,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  output logic [NBANK-1:0]      rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [NBANK*QN-1:0]   rd_data,
  output logic [AXI_DW-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int SLOT_W = 32 * NBANK;
  localparam int RPB    = AXI_DW / SLOT_W;
  localparam int TOTAL  = NBIN * WPB;
  localparam int KW     = (RPB > 1) ? $clog2(RPB) : 1;
  localparam int RW     = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int BW     = $clog2(NBIN + 1);
  localparam int WW     = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(RPB - 1);
  localparam logic [AW-1:0] A_LAST = AW'(TOTAL - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WPB - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic [WW-1:0]     wib_q, wib_d;
  logic [KW-1:0]     k_q, k_d;
  logic [1:0]        inflight_q, inflight_d;
  logic              vld_q, vld_d;
  logic [KW-1:0]     slot_q, slot_d;
  logic [RW-1:0]     rot_q, rot_d;
  logic              lastrd_q, lastrd_d;
  logic [AXI_DW-1:0] asm_q, asm_d;
  logic [AXI_DW-1:0] buf_q [0:1];
  logic [AXI_DW-1:0] buf_d [0:1];
  logic [1:0]        blast_q, blast_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              issue, grp_start, push, pop;
  logic [RW-1:0]     rot_sel;
  logic [SLOT_W-1:0] slot_word;
  logic [QN-1:0]     elem_raw;
  int                bank_idx;

  // Unsigned fraction d/2^QN to float32; the MSB position sets the exponent.
  function automatic logic [31:0] to_float(input logic [QN-1:0] d);
    logic [31:0] r;
    logic [23:0] m;
    int          p;
    r = 32'h0;
    m = 24'h0;
    p = 0;
    for (int i = 0; i < QN; i++) begin
      if (d[i]) p = i;
    end
    if (d != '0) begin
      m = 24'(d) << (23 - p);
      r = {1'b0, 8'(127 - QN + p), m[22:0]};
    end
    return r;
  endfunction

  // A group may only start when it is guaranteed a buffer slot on arrival.
  assign grp_start = (state_q == ST_RUN) && (k_q == '0) &&
                     (({1'b0, cnt_q} + {1'b0, inflight_q}) < 3'd2);
  assign issue     = (state_q == ST_RUN) && ((k_q != '0) || grp_start);
  assign push      = vld_q && (slot_q == K_LAST);
  assign pop       = (cnt_q != 2'd0) && m_ready;

  // Bank rotation for the read being issued, chosen by its bin.
  always_comb begin
    rot_sel = RW'(ROT_C);
    if (int'(bin_q) <= SPLIT1)      rot_sel = RW'(ROT_A);
    else if (int'(bin_q) <= SPLIT2) rot_sel = RW'(ROT_B);
  end

  // Convert the returning read data into one slot of the beat.
  always_comb begin
    slot_word = '0;
    elem_raw  = '0;
    bank_idx  = 0;
    for (int j = 0; j < NBANK; j++) begin
      bank_idx = (int'(rot_q) + j) % NBANK;
      elem_raw = rd_data[bank_idx*QN +: QN];
      case (mode_q)
        2'b00:   slot_word[j*32 +: 32] = to_float(elem_raw);
        2'b01:   slot_word[j*32 +: 32] = 32'(elem_raw);
        default: slot_word[j*32 +: 32] = '1;
      endcase
    end
  end

  // Next-state logic: FSM, address walk, read pipeline and beat buffer.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    bin_d      = bin_q;
    wib_d      = wib_q;
    k_d        = k_q;
    asm_d      = asm_q;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    blast_d    = blast_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    done_d     = 1'b0;
    vld_d      = issue;
    slot_d     = k_q;
    rot_d      = rot_sel;
    lastrd_d   = (addr_q == A_LAST);
    inflight_d = inflight_q + {1'b0, grp_start} - {1'b0, push};
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      k_d    = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      addr_d = addr_q + 1'b1;
      if (wib_q == W_LAST) begin
        wib_d = '0;
        bin_d = bin_q + 1'b1;
      end else begin
        wib_d = wib_q + 1'b1;
      end
      if (addr_q == A_LAST) begin
        state_d = ST_DRAIN;
        addr_d  = '0;
        bin_d   = '0;
        wib_d   = '0;
      end
    end

    if (vld_q) asm_d[int'(slot_q)*SLOT_W +: SLOT_W] = slot_word;

    if (push) begin
      buf_d[wr_q]   = asm_d;
      blast_d[wr_q] = lastrd_q;
      wr_d          = ~wr_q;
    end

    if (pop) begin
      rd_d = ~rd_q;
      if (blast_q[rd_q]) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if ((state_q == ST_IDLE) && start) begin
      state_d = ST_RUN;
      mode_d  = mode;
    end

    if (abort) begin
      state_d    = ST_IDLE;
      addr_d     = '0;
      bin_d      = '0;
      wib_d      = '0;
      k_d        = '0;
      inflight_d = 2'd0;
      vld_d      = 1'b0;
      cnt_d      = 2'd0;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      addr_q     <= '0;
      bin_q      <= '0;
      wib_q      <= '0;
      k_q        <= '0;
      inflight_q <= 2'd0;
      vld_q      <= 1'b0;
      slot_q     <= '0;
      rot_q      <= '0;
      lastrd_q   <= 1'b0;
      asm_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      blast_q    <= 2'b00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      bin_q      <= bin_d;
      wib_q      <= wib_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      slot_q     <= slot_d;
      rot_q      <= rot_d;
      lastrd_q   <= lastrd_d;
      asm_q      <= asm_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      blast_q    <= blast_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign rd_en   = {NBANK{issue}};
  assign rd_addr = addr_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = m_valid ? buf_q[rd_q] : '0;
  assign m_last  = m_valid & blast_q[rd_q];
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_hog_feature_stream_packer.sv
// tb_hog_feature_stream_packer
// Scoreboard bench: expected beats are queued when a frame starts, a monitor
// pops and compares each accepted beat. A BRAM model answers reads.
module tb_hog_feature_stream_packer;

  localparam int QN = 8, NBANK = 4, AXI_DW = 512, AW = 13, NBIN = 31, WPB = 256;
  localparam int SPLIT1 = 17, SPLIT2 = 26, ROT_A = 0, ROT_B = 1, ROT_C = 3;
  localparam int RPB = AXI_DW / (32 * NBANK);
  localparam int BPF = NBIN * WPB / RPB;

  logic                  aclk = 1'b0;
  logic                  arest = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [1:0]            mode = 2'b00;
  logic [NBANK-1:0]      rd_en;
  logic [AW-1:0]         rd_addr;
  logic [NBANK*QN-1:0]   rd_data = '0;
  logic [AXI_DW-1:0]     m_data;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  int vectors = 0;
  int miscompares = 0;
  int pat_sel = 0;
  int seed = 0;
  int beat_cnt = 0;
  int reads = 0;
  int groups = 0;
  int frames_done = 0;
  bit last_acc = 0;
  bit stall_prev = 0;
  logic [AXI_DW:0] prev_beat = '0;
  logic [AXI_DW-1:0] cap0 = '0, cap_b18 = '0, cap_b27 = '0;
  logic [AXI_DW:0] exp_q [$];

  hog_feature_stream_packer #(
    .QN(QN), .NBANK(NBANK), .AXI_DW(AXI_DW), .AW(AW), .NBIN(NBIN), .WPB(WPB),
    .SPLIT1(SPLIT1), .SPLIT2(SPLIT2), .ROT_A(ROT_A), .ROT_B(ROT_B), .ROT_C(ROT_C)
  ) dut (
    .aclk(aclk), .arest(arest), .start(start), .abort(abort), .mode(mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;

  // Contents of bank b at address a for each stimulus pattern.
  function automatic int mem_val(input int pat, input int b, input int a);
    case (pat)
      0:       return (a + b) & 8'hFF;
      1:       return 16 * (b + 1);
      default: return (a * 37 + b * 101 + seed) & 8'hFF;
    endcase
  endfunction

  // Float32 reference built from the real value d/2^QN via the double encoding.
  function automatic logic [31:0] ref_float(input int d);
    real v;
    logic [63:0] bits;
    int e;
    if (d == 0) return 32'h0;
    v = real'(d) / (2.0 ** QN);
    bits = $realtobits(v);
    e = int'(bits[62:52]) - 1023 + 127;
    return {1'b0, e[7:0], bits[51:29]};
  endfunction

  function automatic int rot_of(input int bin);
    if (bin <= SPLIT1) return ROT_A;
    if (bin <= SPLIT2) return ROT_B;
    return ROT_C;
  endfunction

  // Expected beat n of a frame.
  function automatic logic [AXI_DW-1:0] exp_beat(input int n, input int md, input int pat);
    logic [AXI_DW-1:0] r;
    int a, d;
    r = '0;
    for (int k = 0; k < RPB; k++) begin
      a = n * RPB + k;
      for (int j = 0; j < NBANK; j++) begin
        d = mem_val(pat, (rot_of(a / WPB) + j) % NBANK, a);
        if (md == 0)      r[(k*NBANK+j)*32 +: 32] = ref_float(d);
        else if (md == 1) r[(k*NBANK+j)*32 +: 32] = 32'(d);
        else              r[(k*NBANK+j)*32 +: 32] = 32'hFFFF_FFFF;
      end
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [AXI_DW+1:0] act,
                              input logic [AXI_DW+1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM banks: data one cycle after the read enable.
  always @(posedge aclk) begin
    for (int b = 0; b < NBANK; b++)
      if (rd_en[b]) rd_data[b*QN +: QN] <= QN'(mem_val(pat_sel, b, int'(rd_addr)));
  end

  // Monitor: scoreboard pops, hold stability, done timing, buffer-space rule.
  initial begin
    logic [AXI_DW:0] e;
    forever begin
      @(negedge aclk);
      if (arest) begin
        last_acc = 0;
        stall_prev = 0;
      end else begin
        if (last_acc || done) check_output("done_pulse", done, last_acc);
        if (done) frames_done++;
        last_acc = 0;
        if (stall_prev) check_output("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_beat});
        if (rd_en != '0) begin
          if (rd_en !== {NBANK{1'b1}}) check_output("rd_en_lockstep", rd_en, {NBANK{1'b1}});
          if (reads % RPB == 0) begin
            groups++;
            check_output("buffer_space", (groups - beat_cnt) <= 2, 1);
          end
          reads++;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL beat_data: got unexpected beat %0d, expected none", beat_cnt);
          end else begin
            e = exp_q.pop_front();
            check_output("beat_data", {m_last, m_data}, e);
          end
          if (beat_cnt == 0) cap0 = m_data;
          if (beat_cnt == 18 * WPB / RPB) cap_b18 = m_data;
          if (beat_cnt == 27 * WPB / RPB) cap_b27 = m_data;
          beat_cnt++;
          last_acc = m_last;
        end
        stall_prev = m_valid && !m_ready;
        prev_beat = {m_last, m_data};
      end
    end
  end

  task automatic apply_stimulus(input int md, input int pat);
    pat_sel = pat;
    for (int n = 0; n < BPF; n++) exp_q.push_back({(n == BPF - 1), exp_beat(n, md, pat)});
    beat_cnt = 0;
    reads = 0;
    groups = 0;
    @(posedge aclk); #1;
    start = 1'b1;
    mode = 2'(md);
    @(posedge aclk); #1;
    start = 1'b0;
    mode = 2'($urandom_range(3));
  endtask

  task automatic wait_beats(input int n, input int pct);
    int cyc = 0;
    while (beat_cnt < n && cyc < 20000) begin
      @(posedge aclk); #1;
      m_ready = ($urandom_range(99) < pct);
      cyc++;
    end
    if (beat_cnt < n) check_output("timeout_beats", beat_cnt, n);
  endtask

  task automatic run_frame(input int md, input int pat, input int pct, input bit poke);
    int cyc = 0;
    int fd = frames_done;
    apply_stimulus(md, pat);
    while (frames_done == fd && cyc < 30000) begin
      @(posedge aclk); #1;
      m_ready = ($urandom_range(99) < pct);
      start = poke && (cyc % 700 == 350) && (beat_cnt < BPF - 20);
      cyc++;
    end
    start = 1'b0;
    if (frames_done == fd) check_output("timeout_frame", 0, 1);
    check_output("beat_count", beat_cnt, BPF);
    check_output("queue_empty", exp_q.size(), 0);
    check_output("busy_after_done", busy, 0);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    stall_prev = 0;
    check_output("abort_idle", {m_valid, busy, rd_en, rd_addr}, 0);
    exp_q.delete();
  endtask

  initial begin
    int fd;
    seed = int'($urandom_range(255));
    #1 arest = 1'b1;
    #1;
    check_output("reset_ctrl", {rd_en, rd_addr, m_valid, m_last, busy, done}, 0);
    check_output("reset_data", m_data, 0);
    repeat (3) @(posedge aclk);
    #1 arest = 1'b0;

    // Float mode, ramp pattern, always ready.
    run_frame(0, 0, 100, 0);
    check_output("beat0_floats", cap0[127:0],
                 {32'h3C40_0000, 32'h3C00_0000, 32'h3B80_0000, 32'h0000_0000});

    // Same frame under random backpressure.
    run_frame(0, 0, 50, 0);

    // Per-bank constants expose the rotation per bin group.
    run_frame(0, 1, 100, 0);
    check_output("bin18_elem0", cap_b18[31:0], 32'h3E00_0000);
    check_output("bin27_elem0", cap_b27[31:0], 32'h3E80_0000);

    // Raw mode and all-ones test mode.
    run_frame(1, 0, 90, 0);
    check_output("raw_beat0", cap0[127:0],
                 {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000});
    run_frame(2, 2, 60, 0);
    check_output("ones_beat0", cap0, {AXI_DW{1'b1}});

    // Abort at beat 100 with the sink stalled, then restart from beat 0.
    apply_stimulus(0, 0);
    wait_beats(100, 100);
    m_ready = 1'b0;
    repeat (8) @(posedge aclk);
    #1;
    fd = frames_done;
    pulse_abort();
    repeat (5) @(posedge aclk);
    #1;
    check_output("abort_no_done", frames_done, fd);
    apply_stimulus(0, 0);
    wait_beats(20, 100);
    check_output("restart_beat0", cap0[127:0],
                 {32'h3C40_0000, 32'h3C00_0000, 32'h3B80_0000, 32'h0000_0000});
    pulse_abort();
    repeat (4) @(posedge aclk);
    #1;

    // Asynchronous reset in the middle of a frame.
    apply_stimulus(0, 2);
    wait_beats(300, 100);
    arest = 1'b1;
    #1;
    check_output("midrun_reset_ctrl", {rd_en, rd_addr, m_valid, m_last, busy, done}, 0);
    check_output("midrun_reset_data", m_data, 0);
    stall_prev = 0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1 arest = 1'b0;

    // Random data, start pulses while busy must be ignored.
    run_frame(0, 2, 80, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
